// File: rtl/fmul_post_if.sv
// Handshake bundle between fmul_post and its producer/consumer: operands and raw
// product in (valid/ready), post-processed product out (valid/ready).
interface fmul_post_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic [DATA_WIDTH-1:0] p_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] c_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  a_i, b_i, p_i, valid_i, ready_i,
    output ready_o, c_o, valid_o
  );

  modport master (
    output a_i, b_i, p_i, valid_i, ready_i,
    input  ready_o, c_o, valid_o
  );
endinterface

// File: rtl/fmul_post.sv
// IEEE-754 binary64 multiply post-fixup (special operands, overflow/underflow), 1-cycle latency.
// Backpressure: 2-entry FIFO; ready_o depends only on registered occupancy, never on ready_i.
module fmul_post #(
  parameter int DATA_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fmul_post_if.slave  io,
  input  logic        flag_clr_i,
  output logic [2:0]  flags_o,
  output logic [15:0] count_o
);

  typedef struct packed {
    logic [2:0]            tag;
    logic [DATA_WIDTH-1:0] dat;
  } entry_t;

  logic [10:0] a_exp, b_exp, p_exp;
  logic        a_nan, a_inf, a_zero;
  logic        b_nan, b_inf, b_zero;
  logic        sgn;
  entry_t      in_ent;

  assign a_exp  = io.a_i[62:52];
  assign b_exp  = io.b_i[62:52];
  assign p_exp  = io.p_i[62:52];
  assign sgn    = io.a_i[63] ^ io.b_i[63];
  assign a_nan  = (a_exp == 11'h7FF) && (io.a_i[51:0] != 52'h0);
  assign a_inf  = (a_exp == 11'h7FF) && (io.a_i[51:0] == 52'h0);
  assign a_zero = (a_exp == 11'h000);
  assign b_nan  = (b_exp == 11'h7FF) && (io.b_i[51:0] != 52'h0);
  assign b_inf  = (b_exp == 11'h7FF) && (io.b_i[51:0] == 52'h0);
  assign b_zero = (b_exp == 11'h000);

  // Operand classes take priority over the raw product's exponent; denormals count as zero.
  always_comb begin
    in_ent.tag = 3'b000;
    in_ent.dat = io.p_i;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      in_ent.tag = 3'b100;
      in_ent.dat = 64'h7FF8000000000000;
    end else if (a_inf || b_inf) begin
      in_ent.dat = {sgn, 11'h7FF, 52'h0};
    end else if (a_zero || b_zero) begin
      in_ent.dat = {sgn, 63'h0};
    end else if (p_exp == 11'h7FF) begin
      in_ent.tag = 3'b010;
      in_ent.dat = {sgn, 11'h7FF, 52'h0};
    end else if (p_exp == 11'h000) begin
      in_ent.tag = 3'b001;
      in_ent.dat = {sgn, 63'h0};
    end
  end

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic [2:0]  flags_q, flags_d;
  logic [15:0] count_q, count_d;
  entry_t      head;
  logic        push, pop;

  assign head       = mem_q[rd_ptr_q];
  assign io.ready_o = (occ_q < 2'd2);
  assign io.valid_o = (occ_q != 2'd0);
  assign io.c_o     = io.valid_o ? head.dat : '0;
  assign push       = io.valid_i & io.ready_o;
  assign pop        = io.valid_o & io.ready_i;
  assign flags_o    = flags_q;
  assign count_o    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    // Clear first so a tag leaving in the same cycle still lands.
    flags_d  = flag_clr_i ? 3'b000 : flags_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      flags_d  = flags_d | head.tag;
      count_d  = count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      flags_q  <= 3'b000;
      count_q  <= 16'h0000;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/fmul_post.md
FMUL_POST -- requirements
Module: fmul_post

Interface
REQ-001 Parameter DATA_WIDTH, default 64, IEEE-754 binary64 word width; only 64 is supported.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 a_i  input  64  original multiplicand presented to fmul.
REQ-005 b_i  input  64  original multiplier presented to fmul.
REQ-006 p_i  input  64  raw product c_o from fmul for the same a_i/b_i.
REQ-007 valid_i  input  1  a_i/b_i/p_i valid this cycle.
REQ-008 ready_o  output  1  block can accept; transfer in when valid_i&ready_o.
REQ-009 c_o  output  64  post-processed product.
REQ-010 valid_o  output  1  c_o valid.
REQ-011 ready_i  input  1  consumer accepts; transfer out when valid_o&ready_i.
REQ-012 flags_o  output  3  sticky flags {invalid[2], overflow[1], underflow[0]}.
REQ-013 flag_clr_i  input  1  one-cycle pulse clearing flags_o.
REQ-014 count_o  output  16  number of completed output transfers, modulo 2^16.

Function
REQ-015 Field decode per operand: sign bit 63, exp bits 62:52, mant bits 51:0; NaN=exp 7FF & mant!=0; Inf=exp 7FF & mant==0; Zero=exp 000 (denormals flushed to zero).
REQ-016 Result sign s = a_i[63]^b_i[63].
REQ-017 Priority 1: either NaN, or Zero paired with Inf -> result 64'h7FF8000000000000, tag invalid.
REQ-018 Priority 2: either Inf -> result {s, 11'h7FF, 52'h0}, no tag.
REQ-019 Priority 3: either Zero -> result {s, 63'h0}, no tag.
REQ-020 Priority 4: p_i exp==7FF -> {s, 11'h7FF, 52'h0}, tag overflow.
REQ-021 Priority 5: p_i exp==000 -> {s, 63'h0}, tag underflow.
REQ-022 Otherwise result = p_i unchanged, no tag.
REQ-023 Result and tag computed combinationally at input and stored with the entry on input transfer.
REQ-024 Storage: 2-entry FIFO, in-order; ready_o = (occupancy < 2), registered-state-derived, no combinational path from ready_i.
REQ-025 Latency: entry accepted in cycle N is visible on c_o/valid_o from cycle N+1 when FIFO was empty.
REQ-026 Simultaneous in and out transfer with occupancy 1: occupancy stays 1, order preserved.
REQ-027 Full (occupancy 2): ready_o=0; valid_i ignored.
REQ-028 Empty: valid_o=0; c_o holds 64'h0.
REQ-029 c_o/valid_o stable while valid_o&~ready_i.
REQ-030 flags_o bit set on the output transfer of an entry carrying that tag; bits stay set until cleared.
REQ-031 flag_clr_i same cycle as tagged output transfer: clear applied, then that transfer's tag set (set wins).
REQ-032 count_o increments by 1 per output transfer; FFFF wraps to 0000.

Reset
REQ-033 rst_i high at a clock edge: FIFO emptied, valid_o=0, c_o=64'h0, flags_o=3'b000, count_o=16'h0000; ready_o=1 in the cycle after rst_i deasserts.
REQ-034 Reset mid-operation discards all stored entries; no output transfer occurs in the reset cycle.

Verification
REQ-035 a=3FF8000000000000, b=4000000000000000, p=4008000000000000, ready_i=1 -> next cycle c_o=4008000000000000, valid_o=1, flags_o=000, count_o=1.
REQ-036 a=7FF0000000000000, b=0000000000000000, any p -> c_o=7FF8000000000000, flags_o=100; a=BFF0000000000000, b=FFF0000000000000 -> c_o=7FF0000000000000.
REQ-037 a=7FE0000000000000, b=4000000000000000, p=7FF0000000000000 -> c_o=7FF0000000000000, flags_o=010; a=0010000000000000, b=3CB0000000000000, p=0000000000000000 -> c_o=0, flags_o bit0 set.
REQ-038 ready_i=0, offer 3 consecutive products (1.5*2, 2.5*4, 1.75*1.75) -> ready_o low after 2 accepted; on ready_i=1 outputs 4008000000000000, 4024000000000000, 4008800000000000 in order, third accepted only after a pop.
REQ-039 flags_o=010, flag_clr_i pulsed with an invalid-tagged output transfer -> flags_o=100 next cycle; 65536 transfers from reset -> count_o=0000.
REQ-040 Two entries stored, rst_i pulsed one cycle -> valid_o=0, count_o=0, flags_o=000, stored entries never emitted.
